// File: rtl/tlb_rr_pipe.sv
// tlb_rr_pipe: fully associative TLB with two registered search ports,
// TLBWR/TLBFILL write port (round-robin fill pointer), combinational TLBRD
// and INVTLB. Optional macro TLB_PERF_CNT_EN adds miss/invalidate counters.
module tlb_rr_pipe #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s0_req,
  input  logic [18:0]     s0_vppn,
  input  logic            s0_va_bit12,
  input  logic [9:0]      s0_asid,
  output logic            s0_rvalid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_ppn,
  output logic [5:0]      s0_ps,
  output logic [1:0]      s0_plv,
  output logic [1:0]      s0_mat,
  output logic            s0_d,
  output logic            s0_v,
  input  logic            s1_req,
  input  logic [18:0]     s1_vppn,
  input  logic            s1_va_bit12,
  input  logic [9:0]      s1_asid,
  output logic            s1_rvalid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_ppn,
  output logic [5:0]      s1_ps,
  output logic [1:0]      s1_plv,
  output logic [1:0]      s1_mat,
  output logic            s1_d,
  output logic            s1_v,
  input  logic            invtlb_valid,
  input  logic [4:0]      invtlb_op,
  input  logic [9:0]      invtlb_asid,
  input  logic [18:0]     invtlb_vppn,
  input  logic            we,
  input  logic            w_fill,
  input  logic [IDXW-1:0] w_index,
  input  logic            w_e,
  input  logic [5:0]      w_ps,
  input  logic [18:0]     w_vppn,
  input  logic [9:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_ppn0,
  input  logic [1:0]      w_plv0,
  input  logic [1:0]      w_mat0,
  input  logic            w_d0,
  input  logic            w_v0,
  input  logic [19:0]     w_ppn1,
  input  logic [1:0]      w_plv1,
  input  logic [1:0]      w_mat1,
  input  logic            w_d1,
  input  logic            w_v1,
  output logic [IDXW-1:0] fill_index,
`ifdef TLB_PERF_CNT_EN
  output logic [31:0]     s0_miss_cnt,
  output logic [31:0]     s1_miss_cnt,
  output logic [31:0]     inv_cnt,
`endif
  input  logic [IDXW-1:0] r_index,
  output logic            r_e,
  output logic [5:0]      r_ps,
  output logic [18:0]     r_vppn,
  output logic [9:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_ppn0,
  output logic [1:0]      r_plv0,
  output logic [1:0]      r_mat0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_ppn1,
  output logic [1:0]      r_plv1,
  output logic [1:0]      r_mat1,
  output logic            r_d1,
  output logic            r_v1
);

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] index;
    logic [19:0]     ppn;
    logic [5:0]      ps;
    logic [1:0]      plv;
    logic [1:0]      mat;
    logic            d;
    logic            v;
  } res_t;

  // entry state; only E is reset
  logic [TLBNUM-1:0]       e_q, e_d, g_q, g_d, ps4m_q, ps4m_d;
  logic [TLBNUM-1:0][18:0] vppn_q, vppn_d;
  logic [TLBNUM-1:0][9:0]  asid_q, asid_d;
  logic [TLBNUM-1:0][19:0] ppn0_q, ppn0_d, ppn1_q, ppn1_d;
  logic [TLBNUM-1:0][1:0]  plv0_q, plv0_d, plv1_q, plv1_d;
  logic [TLBNUM-1:0][1:0]  mat0_q, mat0_d, mat1_q, mat1_d;
  logic [TLBNUM-1:0]       d0_q, d0_d, d1_q, d1_d, v0_q, v0_d, v1_q, v1_d;
  logic [IDXW-1:0]         fill_q, fill_d;
  logic [IDXW-1:0]         widx;

  // search operands gathered per port
  logic [1:0]       req_in, va12_in;
  logic [1:0][18:0] vppn_in;
  logic [1:0][9:0]  asid_in;

  assign req_in  = {s1_req, s0_req};
  assign va12_in = {s1_va_bit12, s0_va_bit12};
  assign vppn_in = {s1_vppn, s0_vppn};
  assign asid_in = {s1_asid, s0_asid};
  assign widx    = w_fill ? fill_q : w_index;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [TLBNUM-1:0] hit;
    logic [IDXW-1:0]   sel;
    logic              any, odd;
    res_t              res_q, res_d;
    logic              rvalid_q, rvalid_d;

    for (genvar i = 0; i < TLBNUM; i++) begin : g_ent
      assign hit[i] = e_q[i]
                   && (vppn_q[i][18:10] == vppn_in[p][18:10])
                   && (ps4m_q[i] || (vppn_q[i][9:0] == vppn_in[p][9:0]))
                   && (g_q[i] || (asid_q[i] == asid_in[p]));
    end

    // priority-encode (lowest index wins) and build the next registered result
    always_comb begin
      sel = '0;
      any = 1'b0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (hit[i]) begin
          sel = IDXW'(i);
          any = 1'b1;
        end
      end
      odd      = ps4m_q[sel] ? vppn_in[p][9] : va12_in[p];
      rvalid_d = req_in[p];
      res_d    = res_q;
      if (req_in[p]) begin
        res_d = '0;
        if (any) begin
          res_d.found = 1'b1;
          res_d.index = sel;
          res_d.ps    = ps4m_q[sel] ? 6'd22 : 6'd12;
          res_d.ppn   = odd ? ppn1_q[sel] : ppn0_q[sel];
          res_d.plv   = odd ? plv1_q[sel] : plv0_q[sel];
          res_d.mat   = odd ? mat1_q[sel] : mat0_q[sel];
          res_d.d     = odd ? d1_q[sel]   : d0_q[sel];
          res_d.v     = odd ? v1_q[sel]   : v0_q[sel];
        end
      end
    end

    // registered lookup result
    always_ff @(posedge clk) begin
      if (reset) begin
        res_q    <= '0;
        rvalid_q <= 1'b0;
      end else begin
        res_q    <= res_d;
        rvalid_q <= rvalid_d;
      end
    end

`ifdef TLB_PERF_CNT_EN
    logic [31:0] miss_q, miss_d;
    // saturating miss counter on each delivered miss
    always_comb begin
      miss_d = miss_q;
      if (rvalid_q && !res_q.found && (miss_q != 32'hFFFF_FFFF)) miss_d = miss_q + 32'd1;
    end
    always_ff @(posedge clk) begin
      if (reset) miss_q <= '0;
      else       miss_q <= miss_d;
    end
`endif
  end

  assign s0_rvalid = g_port[0].rvalid_q;
  assign s0_found  = g_port[0].res_q.found;
  assign s0_index  = g_port[0].res_q.index;
  assign s0_ppn    = g_port[0].res_q.ppn;
  assign s0_ps     = g_port[0].res_q.ps;
  assign s0_plv    = g_port[0].res_q.plv;
  assign s0_mat    = g_port[0].res_q.mat;
  assign s0_d      = g_port[0].res_q.d;
  assign s0_v      = g_port[0].res_q.v;
  assign s1_rvalid = g_port[1].rvalid_q;
  assign s1_found  = g_port[1].res_q.found;
  assign s1_index  = g_port[1].res_q.index;
  assign s1_ppn    = g_port[1].res_q.ppn;
  assign s1_ps     = g_port[1].res_q.ps;
  assign s1_plv    = g_port[1].res_q.plv;
  assign s1_mat    = g_port[1].res_q.mat;
  assign s1_d      = g_port[1].res_q.d;
  assign s1_v      = g_port[1].res_q.v;

  // E bits: invalidate matching entries, then the write target takes w_e
  always_comb begin
    logic asid_eq, va_eq, kill;
    asid_eq = 1'b0;
    va_eq   = 1'b0;
    kill    = 1'b0;
    e_d     = e_q;
    if (invtlb_valid) begin
      for (int i = 0; i < TLBNUM; i++) begin
        asid_eq = (asid_q[i] == invtlb_asid);
        va_eq   = (vppn_q[i][18:10] == invtlb_vppn[18:10])
               && (ps4m_q[i] || (vppn_q[i][9:0] == invtlb_vppn[9:0]));
        case (invtlb_op)
          5'd0, 5'd1: kill = 1'b1;
          5'd2:       kill = g_q[i];
          5'd3:       kill = !g_q[i];
          5'd4:       kill = !g_q[i] && asid_eq;
          5'd5:       kill = !g_q[i] && asid_eq && va_eq;
          5'd6:       kill = (g_q[i] || asid_eq) && va_eq;
          default:    kill = 1'b0;
        endcase
        if (kill) e_d[i] = 1'b0;
      end
    end
    if (we) e_d[widx] = w_e;
  end

  // non-E entry fields and the round-robin fill pointer
  always_comb begin
    g_d = g_q;   ps4m_d = ps4m_q; vppn_d = vppn_q; asid_d = asid_q;
    ppn0_d = ppn0_q; plv0_d = plv0_q; mat0_d = mat0_q; d0_d = d0_q; v0_d = v0_q;
    ppn1_d = ppn1_q; plv1_d = plv1_q; mat1_d = mat1_q; d1_d = d1_q; v1_d = v1_q;
    fill_d = fill_q;
    if (we) begin
      g_d[widx]    = w_g;
      ps4m_d[widx] = (w_ps == 6'd22);
      vppn_d[widx] = w_vppn;
      asid_d[widx] = w_asid;
      ppn0_d[widx] = w_ppn0; plv0_d[widx] = w_plv0; mat0_d[widx] = w_mat0;
      d0_d[widx]   = w_d0;   v0_d[widx]   = w_v0;
      ppn1_d[widx] = w_ppn1; plv1_d[widx] = w_plv1; mat1_d[widx] = w_mat1;
      d1_d[widx]   = w_d1;   v1_d[widx]   = w_v1;
      if (w_fill) fill_d = fill_q + 1'b1;
    end
  end

  // resettable state
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q    <= '0;
      fill_q <= '0;
    end else begin
      e_q    <= e_d;
      fill_q <= fill_d;
    end
  end

  // entry payload, deliberately not reset
  always_ff @(posedge clk) begin
    g_q <= g_d;   ps4m_q <= ps4m_d; vppn_q <= vppn_d; asid_q <= asid_d;
    ppn0_q <= ppn0_d; plv0_q <= plv0_d; mat0_q <= mat0_d; d0_q <= d0_d; v0_q <= v0_d;
    ppn1_q <= ppn1_d; plv1_q <= plv1_d; mat1_q <= mat1_d; d1_q <= d1_d; v1_q <= v1_d;
  end

  assign fill_index = fill_q;

`ifdef TLB_PERF_CNT_EN
  logic [31:0] inv_cnt_q, inv_cnt_d;
  // count executed INVTLBs with a defined op
  always_comb begin
    inv_cnt_d = inv_cnt_q;
    if (invtlb_valid && (invtlb_op <= 5'd6)) inv_cnt_d = inv_cnt_q + 32'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) inv_cnt_q <= '0;
    else       inv_cnt_q <= inv_cnt_d;
  end
  assign s0_miss_cnt = g_port[0].miss_q;
  assign s1_miss_cnt = g_port[1].miss_q;
  assign inv_cnt     = inv_cnt_q;
`endif

  // TLBRD: combinational view of current state
  assign r_e    = e_q[r_index];
  assign r_ps   = ps4m_q[r_index] ? 6'd22 : 6'd12;
  assign r_vppn = vppn_q[r_index];
  assign r_asid = asid_q[r_index];
  assign r_g    = g_q[r_index];
  assign r_ppn0 = ppn0_q[r_index];
  assign r_plv0 = plv0_q[r_index];
  assign r_mat0 = mat0_q[r_index];
  assign r_d0   = d0_q[r_index];
  assign r_v0   = v0_q[r_index];
  assign r_ppn1 = ppn1_q[r_index];
  assign r_plv1 = plv1_q[r_index];
  assign r_mat1 = mat1_q[r_index];
  assign r_d1   = d1_q[r_index];
  assign r_v1   = v1_q[r_index];

endmodule

// File: tb/tb_tlb_rr_pipe.sv
// Bench for tlb_rr_pipe: lookup expectations go into a scoreboard queue when a
// request is driven and are popped when the registered result appears.
module tb_tlb_rr_pipe;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic s0_req = 0, s0_va_bit12 = 0, s1_req = 0, s1_va_bit12 = 0;
  logic [18:0] s0_vppn = '0, s1_vppn = '0, invtlb_vppn = '0, w_vppn = '0;
  logic [9:0]  s0_asid = '0, s1_asid = '0, invtlb_asid = '0, w_asid = '0;
  logic s0_rvalid, s0_found, s0_d, s0_v, s1_rvalid, s1_found, s1_d, s1_v;
  logic [IDXW-1:0] s0_index, s1_index, fill_index;
  logic [19:0] s0_ppn, s1_ppn;
  logic [5:0]  s0_ps, s1_ps;
  logic [1:0]  s0_plv, s0_mat, s1_plv, s1_mat;
  logic invtlb_valid = 0;
  logic [4:0] invtlb_op = '0;
  logic we = 0, w_fill = 0, w_e = 0, w_g = 0, w_d0 = 0, w_v0 = 0, w_d1 = 0, w_v1 = 0;
  logic [IDXW-1:0] w_index = '0, r_index = '0;
  logic [5:0] w_ps = '0;
  logic [19:0] w_ppn0 = '0, w_ppn1 = '0;
  logic [1:0] w_plv0 = '0, w_mat0 = '0, w_plv1 = '0, w_mat1 = '0;
  logic r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic [5:0] r_ps;
  logic [18:0] r_vppn;
  logic [9:0] r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0] r_plv0, r_mat0, r_plv1, r_mat1;

  int total = 0, bad = 0;
  logic [31:0] sbq[$];
  logic [31:0] ex;
  logic [15:0] ev;

  tlb_rr_pipe #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset),
    .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_rvalid(s0_rvalid), .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn),
    .s0_ps(s0_ps), .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
    .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_rvalid(s1_rvalid), .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn),
    .s1_ps(s1_ps), .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
    .invtlb_vppn(invtlb_vppn),
    .we(we), .w_fill(w_fill), .w_index(w_index), .w_e(w_e), .w_ps(w_ps), .w_vppn(w_vppn),
    .w_asid(w_asid), .w_g(w_g), .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0),
    .w_d0(w_d0), .w_v0(w_v0), .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1),
    .w_d1(w_d1), .w_v1(w_v1), .fill_index(fill_index),
    .r_index(r_index), .r_e(r_e), .r_ps(r_ps), .r_vppn(r_vppn), .r_asid(r_asid), .r_g(r_g),
    .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
    .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] mk(input logic f, input logic [3:0] i,
                                     input logic [19:0] p, input logic [5:0] s);
    return {1'b1, f, i, p, s};
  endfunction

  function automatic logic [31:0] obs(input int p);
    if (p == 0) return {s0_rvalid, s0_found, s0_index, s0_ppn, s0_ps};
    return {s1_rvalid, s1_found, s1_index, s1_ppn, s1_ps};
  endfunction

  // write-port fields; odd/even attribute constants are fixed so reads are predictable
  task automatic set_w(input logic fill, input logic [3:0] idx, input logic e,
                       input logic [5:0] ps, input logic [18:0] vp, input logic [9:0] as,
                       input logic g, input logic [19:0] p0, input logic [19:0] p1);
    w_fill = fill; w_index = idx; w_e = e; w_ps = ps; w_vppn = vp; w_asid = as; w_g = g;
    w_ppn0 = p0; w_plv0 = 2'd1; w_mat0 = 2'd1; w_d0 = 1'b1; w_v0 = 1'b1;
    w_ppn1 = p1; w_plv1 = 2'd3; w_mat1 = 2'd2; w_d1 = 1'b0; w_v1 = 1'b1;
  endtask

  task automatic wr(input logic fill, input logic [3:0] idx, input logic e,
                    input logic [5:0] ps, input logic [18:0] vp, input logic [9:0] as,
                    input logic g, input logic [19:0] p0, input logic [19:0] p1);
    set_w(fill, idx, e, ps, vp, as, g, p0, p1);
    we = 1'b1; tick(); we = 1'b0;
  endtask

  task automatic look(input int p, input logic [18:0] vp, input logic b12, input logic [9:0] as);
    if (p == 0) begin s0_req = 1; s0_vppn = vp; s0_va_bit12 = b12; s0_asid = as; end
    else        begin s1_req = 1; s1_vppn = vp; s1_va_bit12 = b12; s1_asid = as; end
    tick();
    s0_req = 0; s1_req = 0;
  endtask

  task automatic inv(input logic [4:0] op, input logic [9:0] as, input logic [18:0] vp);
    invtlb_valid = 1; invtlb_op = op; invtlb_asid = as; invtlb_vppn = vp;
    tick();
    invtlb_valid = 0;
  endtask

  task automatic read_e(output logic [15:0] v);
    v = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      r_index = 4'(i); #1; v[i] = r_e;
    end
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    tick(); tick(); reset = 0;
    total++;
    if ({s0_rvalid, s1_rvalid, s0_found, s1_found, s0_ppn, s1_ppn} !== '0) begin
      bad++; $display("FAIL reset_outputs got %b%b%b%b want 0", s0_rvalid, s1_rvalid, s0_found, s1_found);
    end
    total++;
    if (fill_index !== 4'd0) begin bad++; $display("FAIL reset_fill got %0d want 0", fill_index); end
    read_e(ev);
    total++;
    if (ev !== 16'h0) begin bad++; $display("FAIL reset_e got %h want 0000", ev); end
  endtask

  task automatic test_lookup();
    wr(0, 3, 1, 12, 19'h00010, 10'd5, 0, 20'h111, 20'h222);
    sbq.push_back(mk(1, 3, 20'h222, 12));
    look(0, 19'h00010, 1, 10'd5);
    ex = sbq.pop_front(); total++;
    if (obs(0) !== ex) begin bad++; $display("FAIL lookup_odd got %h want %h", obs(0), ex); end
    total++;
    if ({s0_plv, s0_mat, s0_d, s0_v} !== {2'd3, 2'd2, 1'b0, 1'b1}) begin
      bad++; $display("FAIL lookup_attr got %b want 111001", {s0_plv, s0_mat, s0_d, s0_v});
    end
    tick();
    total++;
    if ({s0_rvalid, s0_found, s0_ppn} !== {1'b0, 1'b1, 20'h222}) begin
      bad++; $display("FAIL hold got rv=%b f=%b ppn=%h want 0 1 222", s0_rvalid, s0_found, s0_ppn);
    end
    sbq.push_back(mk(1, 3, 20'h111, 12));
    look(0, 19'h00010, 0, 10'd5);
    ex = sbq.pop_front(); total++;
    if (obs(0) !== ex) begin bad++; $display("FAIL lookup_even got %h want %h", obs(0), ex); end
    sbq.push_back(mk(0, 0, 20'h0, 0));
    look(0, 19'h00010, 1, 10'd6);
    ex = sbq.pop_front(); total++;
    if (obs(0) !== ex) begin bad++; $display("FAIL asid_miss got %h want %h", obs(0), ex); end
    total++;
    if ({s0_plv, s0_mat, s0_d, s0_v} !== 6'd0) begin
      bad++; $display("FAIL miss_attr got %b want 000000", {s0_plv, s0_mat, s0_d, s0_v});
    end
    wr(0, 3, 1, 12, 19'h00010, 10'd5, 1, 20'h111, 20'h222);
    sbq.push_back(mk(1, 3, 20'h222, 12));
    look(0, 19'h00010, 1, 10'd6);
    ex = sbq.pop_front(); total++;
    if (obs(0) !== ex) begin bad++; $display("FAIL global_hit got %h want %h", obs(0), ex); end
  endtask

  task automatic test_4mb();
    wr(0, 7, 1, 22, 19'h40000, 10'd5, 0, 20'h333, 20'h444);
    sbq.push_back(mk(1, 7, 20'h444, 22));
    look(1, 19'h40200, 0, 10'd5);
    ex = sbq.pop_front(); total++;
    if (obs(1) !== ex) begin bad++; $display("FAIL big_odd got %h want %h", obs(1), ex); end
    total++;
    if ({s1_plv, s1_mat, s1_d, s1_v} !== {2'd3, 2'd2, 1'b0, 1'b1}) begin
      bad++; $display("FAIL big_attr got %b want 111001", {s1_plv, s1_mat, s1_d, s1_v});
    end
    sbq.push_back(mk(1, 7, 20'h333, 22));
    look(1, 19'h40000, 1, 10'd5);
    ex = sbq.pop_front(); total++;
    if (obs(1) !== ex) begin bad++; $display("FAIL big_even got %h want %h", obs(1), ex); end
    wr(0, 2, 1, 22, 19'h40000, 10'd5, 0, 20'h555, 20'h666);
    sbq.push_back(mk(1, 2, 20'h666, 22));
    look(1, 19'h40200, 0, 10'd5);
    ex = sbq.pop_front(); total++;
    if (obs(1) !== ex) begin bad++; $display("FAIL dup_prio got %h want %h", obs(1), ex); end
  endtask

  task automatic test_same_cycle();
    set_w(0, 9, 1, 12, 19'h00777, 10'd1, 0, 20'h999, 20'h998);
    we = 1; s0_req = 1; s0_vppn = 19'h00777; s0_va_bit12 = 0; s0_asid = 10'd1;
    sbq.push_back(mk(0, 0, 20'h0, 0));
    tick();
    we = 0; s0_req = 0;
    ex = sbq.pop_front(); total++;
    if (obs(0) !== ex) begin bad++; $display("FAIL same_cycle_write got %h want %h", obs(0), ex); end
    sbq.push_back(mk(1, 9, 20'h999, 12));
    look(0, 19'h00777, 0, 10'd1);
    ex = sbq.pop_front(); total++;
    if (obs(0) !== ex) begin bad++; $display("FAIL after_write got %h want %h", obs(0), ex); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k <= TLBNUM; k++) begin
      total++;
      if (fill_index !== 4'(k % TLBNUM)) begin
        bad++; $display("FAIL fill_ptr k=%0d got %0d want %0d", k, fill_index, k % TLBNUM);
      end
      wr(1, 4'hF, 1, 12, 19'(32'h1000 + k), 10'd1, 0, 20'(k), 20'h0);
      if (k == 5) begin
        wr(0, 12, 1, 12, 19'h2222, 10'd1, 0, 20'h1, 20'h2);
        total++;
        if (fill_index !== 4'd6) begin bad++; $display("FAIL tlbwr_keeps_ptr got %0d want 6", fill_index); end
      end
    end
    total++;
    if (fill_index !== 4'd1) begin bad++; $display("FAIL fill_wrap got %0d want 1", fill_index); end
    r_index = 4'd0; #1;
    total++;
    if ({r_vppn, r_ppn0} !== {19'h1010, 20'd16}) begin
      bad++; $display("FAIL fill_rewrite got %h/%h want 1010/10", r_vppn, r_ppn0);
    end
    r_index = 4'd5; #1;
    total++;
    if ({r_e, r_ps, r_vppn, r_asid, r_g, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
         r_ppn1, r_plv1, r_mat1, r_d1, r_v1} !==
        {1'b1, 6'd12, 19'h1005, 10'd1, 1'b0, 20'd5, 2'd1, 2'd1, 1'b1, 1'b1,
         20'd0, 2'd3, 2'd2, 1'b0, 1'b1}) begin
      bad++; $display("FAIL tlbrd got e=%b ps=%0d vppn=%h ppn0=%h", r_e, r_ps, r_vppn, r_ppn0);
    end
  endtask

  task automatic test_invtlb();
    do_reset();
    wr(0, 0, 1, 12, 19'h100, 10'd5, 0, 20'h0, 20'h0);
    wr(0, 1, 1, 12, 19'h101, 10'd5, 1, 20'h0, 20'h0);
    wr(0, 2, 1, 12, 19'h102, 10'd6, 0, 20'h0, 20'h0);
    wr(0, 3, 1, 12, 19'h103, 10'd6, 1, 20'h0, 20'h0);
    wr(0, 4, 1, 22, 19'h200, 10'd5, 0, 20'h0, 20'h0);
    inv(5'd4, 10'd5, 19'h0);
    read_e(ev); total++;
    if (ev !== 16'h000E) begin bad++; $display("FAIL inv_op4 got %h want 000e", ev); end
    inv(5'd7, 10'd5, 19'h101);
    read_e(ev); total++;
    if (ev !== 16'h000E) begin bad++; $display("FAIL inv_op7 got %h want 000e", ev); end
    inv(5'd6, 10'd6, 19'h101);
    read_e(ev); total++;
    if (ev !== 16'h000C) begin bad++; $display("FAIL inv_op6 got %h want 000c", ev); end
    inv(5'd5, 10'd6, 19'h102);
    read_e(ev); total++;
    if (ev !== 16'h0008) begin bad++; $display("FAIL inv_op5 got %h want 0008", ev); end
    inv(5'd2, 10'd0, 19'h0);
    read_e(ev); total++;
    if (ev !== 16'h0000) begin bad++; $display("FAIL inv_op2 got %h want 0000", ev); end
    r_index = 4'd4; #1; total++;
    if (r_ps !== 6'd22) begin bad++; $display("FAIL rd_ps got %0d want 22", r_ps); end
    wr(0, 0, 1, 12, 19'h100, 10'd5, 0, 20'h0, 20'h0);
    wr(0, 1, 1, 12, 19'h101, 10'd5, 1, 20'h0, 20'h0);
    set_w(0, 5, 1, 12, 19'h300, 10'd5, 0, 20'h0, 20'h0);
    we = 1; inv(5'd0, 10'd0, 19'h0); we = 0;
    read_e(ev); total++;
    if (ev !== 16'h0020) begin bad++; $display("FAIL we_with_inv got %h want 0020", ev); end
  endtask

  task automatic test_reset_req();
    do_reset();
    wr(1, 0, 1, 12, 19'h55, 10'd3, 0, 20'hABC, 20'hABD);
    wr(1, 0, 1, 12, 19'h56, 10'd3, 0, 20'h0, 20'h0);
    sbq.push_back(mk(1, 0, 20'hABC, 12));
    look(0, 19'h55, 0, 10'd3);
    ex = sbq.pop_front(); total++;
    if (obs(0) !== ex) begin bad++; $display("FAIL pre_reset_hit got %h want %h", obs(0), ex); end
    s0_req = 1; s0_vppn = 19'h55; s0_asid = 10'd3;
    set_w(0, 6, 1, 12, 19'h66, 10'd3, 0, 20'h0, 20'h0);
    we = 1; reset = 1;
    tick();
    reset = 0; we = 0; s0_req = 0;
    total++;
    if ({s0_rvalid, s0_found, s0_ppn, fill_index} !== '0) begin
      bad++; $display("FAIL reset_req got rv=%b f=%b ppn=%h fill=%0d want 0", s0_rvalid, s0_found, s0_ppn, fill_index);
    end
    read_e(ev); total++;
    if (ev !== 16'h0000) begin bad++; $display("FAIL reset_req_e got %h want 0000", ev); end
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_4mb();
    test_same_cycle();
    test_fill();
    test_invtlb();
    test_reset_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
